receiver_packer: RTL and testbench
==================================

Name: receiver_packer

Overview:
- Parametrised byte-to-word assembler with an output FIFO, sitting between the UART byte receiver and the core's input-word consumer.
- Packs BYTES_PER_WORD serial bytes into one word and queues up to 2**DEPTH_LOG2 words.
- Adds byte-order selection, flush, fill level, a sticky overflow flag and partial-word status.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 1..8.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 words; legal range 1..8.
- BIG_ENDIAN, 0, 0: first byte received lands in out[7:0]; 1: first byte received lands in the top byte of out.
- TIMEOUT_CYCLES, 100000, idle cycles before a partial word is discarded; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_byte  in  8  received byte.
- in_valid  in  1  one-cycle strobe; in_byte is valid this cycle. There is no backpressure toward the receiver.
- clear  in  1  synchronous flush of FIFO, assembly state and overflow flag.
- ready  in  1  consumer accepts the head word this cycle.
- out  out  8*BYTES_PER_WORD  head word of the FIFO; combinational read of distributed storage.
- valid  out  1  FIFO non-empty.
- level  out  DEPTH_LOG2+1  number of stored words, 0..2**DEPTH_LOG2.
- partial  out  1  at least one byte of an incomplete word is held.
- overflow  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - read/write pointers, level, byte index and overflow go to 0;
  - hence valid=0, partial=0, overflow=0;
  - storage contents are not reset; out is undefined while valid=0.
- clear=1 has the same effect as rst, but rst takes priority when both are asserted.
- A byte or pop arriving in the same cycle as clear or rst is discarded.
- Assembly:
  - a byte index 0..BYTES_PER_WORD-1 advances on every in_valid;
  - each byte is written straight into the storage entry at the write pointer, into the lane selected by index and BIG_ENDIAN;
  - partial = (index != 0).
- Commit:
  - when in_valid arrives with index == BYTES_PER_WORD-1, the word commits: write pointer +1, index returns to 0;
  - valid rises on the next cycle (1-cycle latency from last byte to valid);
  - with BYTES_PER_WORD=1 every byte commits.
- Full:
  - full = (level == 2**DEPTH_LOG2);
  - a byte arriving while full and not popping in the same cycle is not written; index still advances, so framing is preserved;
  - if that byte completes a word, the word is dropped: write pointer unchanged, overflow set;
  - earlier bytes of such a word are also lost, because the write-pointer entry is the oldest unread word and must not be overwritten;
  - a byte arriving while full with pop=1 in the same cycle is accepted (the pop frees the slot first).
- Pop:
  - pop = valid && ready; the read pointer advances by 1;
  - ready while empty has no effect.
- Level:
  - +1 on commit only, -1 on pop only, unchanged when both or neither occur.
- Wrap-around: pointers are DEPTH_LOG2 bits and wrap modulo depth; full/empty are decided from level, not from pointer equality.
- Overflow stays set until rst or clear.

Optional Feature:
- Macro: RECEIVER_PACKER_TIMEOUT_EN.
- Defined:
  - an idle counter is cleared on every in_valid and counts while partial=1;
  - when it reaches TIMEOUT_CYCLES-1 with no byte, index returns to 0, the held bytes are discarded (write pointer unchanged), and the counter resets;
  - this resynchronises after a lost byte;
  - a byte arriving in the same cycle as expiry is treated as byte 0 of a new word.
- Undefined: no counter; a partial word waits indefinitely; TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 with BYTES_PER_WORD=4, BIG_ENDIAN=0 -> valid rises the cycle after 0x44, out=0x44332211, level=1; ready=1 -> valid=0, level=0.
- Same bytes with BIG_ENDIAN=1 -> out=0x11223344; after 2 bytes partial=1, valid=0.
- DEPTH_LOG2=2, 5 words sent with ready=0 -> level=4 and overflow=1 after the 5th word; pops return words 1..4 in order, then valid=0.
- Level=4, last byte of a word arriving in the same cycle as a pop -> word accepted, level stays 4, overflow stays 0.
- Two bytes sent, then clear=1 -> partial=0, level=0, overflow=0; the next 4 bytes form one clean word.
- With RECEIVER_PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=16: 3 bytes, 16 idle cycles, then 0xAA,0xBB,0xCC,0xDD -> out=0xDDCCBBAA; without the macro -> out=0xAA<<24 | first three bytes.

Source files
------------

// File: rtl/receiver_packer.sv
// receiver_packer: assembles BYTES_PER_WORD received bytes into a word and
// queues completed words in a 2**DEPTH_LOG2 entry FIFO.
// Optional macro RECEIVER_PACKER_TIMEOUT_EN discards a partial word after
// TIMEOUT_CYCLES idle cycles so framing can resynchronise after a lost byte.
//
// Handshake: the receiver side has no backpressure (in_valid is a strobe);
// the consumer side pops the head word when valid && ready at a rising edge.
module receiver_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH_LOG2     = 4,
    parameter int BIG_ENDIAN     = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    input  logic                        clear,
    input  logic                        ready,
    output logic [8*BYTES_PER_WORD-1:0] out,
    output logic                        valid,
    output logic [DEPTH_LOG2:0]         level,
    output logic                        partial,
    output logic                        overflow
);

    localparam int W       = 8 * BYTES_PER_WORD;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int IDX_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    ovf_q, ovf_d;

    logic                    flush, full, pop, byte_in, last_byte;
    logic                    wr_en, commit, drop, expire;
    logic [IDX_W-1:0]        eff_idx, lane;

    // Next-state decode: byte acceptance, commit, drop and pointer updates
    always_comb begin
        flush     = rst | clear;
        full      = (level_q == LEVEL_W'(DEPTH));
        pop       = (level_q != '0) && ready && !flush;
        // An expiring partial word is abandoned, so a byte in that cycle starts afresh
        eff_idx   = expire ? '0 : idx_q;
        byte_in   = in_valid && !flush;
        last_byte = (eff_idx == IDX_W'(BYTES_PER_WORD - 1));
        // While full the write entry is the oldest unread word; only a same-cycle pop frees it
        wr_en     = byte_in && (!full || pop);
        commit    = wr_en && last_byte;
        drop      = byte_in && last_byte && full && !pop;
        lane      = (BIG_ENDIAN != 0) ? (IDX_W'(BYTES_PER_WORD - 1) - eff_idx) : eff_idx;
        // Index advances even for unwritten bytes so word framing is kept
        idx_d     = byte_in ? (last_byte ? '0 : eff_idx + IDX_W'(1)) : eff_idx;
        wptr_d    = commit ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
        level_d   = level_q;
        if (commit && !pop) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (pop && !commit) begin
            level_d = level_q - LEVEL_W'(1);
        end
        ovf_d     = ovf_q | drop;
    end

    // Control state registers; rst and clear both flush, bytes and pops are ignored then
    always_ff @(posedge clk) begin
        if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Word storage: each byte goes straight into its lane of the write entry (not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q][8*int'(lane) +: 8] <= in_byte;
        end
    end

`ifdef RECEIVER_PACKER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] idle_q;

    assign expire = (idx_q != '0) && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: restarts on every byte, runs only while a partial word is held
    always_ff @(posedge clk) begin
        if (flush || in_valid || expire) begin
            idle_q <= '0;
        end else if (idx_q != '0) begin
            idle_q <= idle_q + TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign out      = mem_q[rptr_q];
    assign valid    = (level_q != '0);
    assign level    = level_q;
    assign partial  = (idx_q != '0);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_receiver_packer.sv
// Bench for receiver_packer: two instances (little and big endian, depth 4)
// share one stimulus stream; a word-level reference model feeds an expected
// queue that a monitor pops whenever a word is handed to the consumer.
module tb_receiver_packer;
  localparam int BPW = 4;
  localparam int DL2 = 2;
  localparam int DEPTH = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst, clear, ready, in_valid;
  logic [7:0] in_byte;
  logic [31:0] out_le, out_be;
  logic valid_le, valid_be, partial_le, partial_be, ovf_le, ovf_be;
  logic [DL2:0] level_le, level_be;

  // expected words in little-endian lane order plus a flag saying whether
  // every byte of the word was actually stored
  logic [31:0] exp_q[$];
  bit known_q[$];
  logic [7:0] m_bytes[$];
  bit m_taint, m_ovf, done;
  int m_level, cyc, m_last;
  int checks, errors;

  receiver_packer #(.BYTES_PER_WORD(BPW), .DEPTH_LOG2(DL2), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO)) dut_le (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .clear(clear), .ready(ready),
    .out(out_le), .valid(valid_le), .level(level_le), .partial(partial_le), .overflow(ovf_le));

  receiver_packer #(.BYTES_PER_WORD(BPW), .DEPTH_LOG2(DL2), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) dut_be (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .clear(clear), .ready(ready),
    .out(out_be), .valid(valid_be), .level(level_be), .partial(partial_be), .overflow(ovf_be));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // driver: applies one cycle of inputs and updates the reference model
  // for the rising edge that follows
  task automatic step(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    bit pop, full;
    logic [31:0] w;
    @(negedge clk);
    in_valid = bv;
    in_byte = b;
    ready = rdy;
    clear = clr;
    cyc++;
    if (clr) begin
      exp_q.delete();
      known_q.delete();
      m_bytes.delete();
      m_taint = 0;
      m_ovf = 0;
      m_level = 0;
      return;
    end
`ifdef RECEIVER_PACKER_TIMEOUT_EN
    if (m_bytes.size() > 0 && cyc - m_last >= TO) begin
      m_bytes.delete();
      m_taint = 0;
    end
`endif
    pop = rdy && (m_level > 0);
    full = (m_level == DEPTH);
    if (bv) begin
      m_last = cyc;
      if (full && !pop) m_taint = 1;
      m_bytes.push_back(b);
      if (m_bytes.size() == BPW) begin
        if (full && !pop) begin
          m_ovf = 1;
        end else begin
          w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          exp_q.push_back(w);
          known_q.push_back(!m_taint);
          m_level++;
        end
        m_bytes.delete();
        m_taint = 0;
      end
    end
    if (pop) m_level--;
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input bit rdy);
    step(1, b0, rdy, 0);
    step(1, b1, rdy, 0);
    step(1, b2, rdy, 0);
    step(1, b3, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
  endtask

  // scoreboard: status outputs against the model after every edge
  always @(posedge clk) begin
    #2;
    if (!rst && !done) begin
      check("valid_le", 32'(valid_le), 32'(m_level > 0));
      check("valid_be", 32'(valid_be), 32'(m_level > 0));
      check("level_le", 32'(level_le), 32'(m_level));
      check("level_be", 32'(level_be), 32'(m_level));
      check("partial_le", 32'(partial_le), 32'(m_bytes.size() > 0));
      check("partial_be", 32'(partial_be), 32'(m_bytes.size() > 0));
      check("overflow_le", 32'(ovf_le), 32'(m_ovf));
      check("overflow_be", 32'(ovf_be), 32'(m_ovf));
    end
  end

  // scoreboard: pop and compare each word the consumer takes
  always @(negedge clk) begin
    logic [31:0] w;
    bit k;
    #3;
    if (!done && !rst && !clear && valid_le && ready) begin
      if (exp_q.size() == 0) begin
        check("pop_on_empty_model", 32'(valid_le), 32'd0);
      end else begin
        w = exp_q.pop_front();
        k = known_q.pop_front();
        if (k) begin
          check("word_le", out_le, w);
          check("word_be", out_be, bswap(w));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    ready = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    check("reset_valid", 32'(valid_le), 32'd0);
    check("reset_level", 32'(level_le), 32'd0);
    check("reset_partial", 32'(partial_be), 32'd0);
    check("reset_overflow", 32'(ovf_be), 32'd0);

    // basic word, both byte orders; partial after two bytes
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    idle(1, 0);
    send_word(8'h33, 8'h44, 8'h55, 8'h66, 0);
    idle(2, 0);
    idle(3, 1);
    step(0, 8'h00, 0, 1);
    idle(1, 0);

    // fill, then complete a word while full with a same-cycle pop
    for (int i = 0; i < 4; i++) send_word(8'(i + 1), 8'h10, 8'h20, 8'h30, 0);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    step(1, 8'hA4, 1, 0);
    idle(6, 1);

    // overflow: five words into a four-deep queue, then drain in order
    for (int i = 0; i < 5; i++) send_word(8'(8'hC0 + i), 8'h01, 8'h02, 8'h03, 0);
    idle(7, 1);
    step(0, 8'h00, 0, 1);

    // two bytes then clear, followed by a clean word
    step(1, 8'hE1, 0, 0);
    step(1, 8'hE2, 0, 0);
    step(0, 8'h00, 0, 1);
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 0);
    idle(2, 1);

    // three bytes, a long idle gap, then a full word
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    idle(TO, 0);
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
    idle(4, 1);
    send_word(8'h5A, 8'h6B, 8'h7C, 8'h8D, 1);
    idle(6, 1);

    // randomized traffic with varying byte rate, consumer rate and rare clears
    for (int ph = 0; ph < 40; ph++) begin
      int p_byte, p_rdy;
      p_byte = $urandom_range(10, 100);
      p_rdy = $urandom_range(0, 100);
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 99) < p_byte, 8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < p_rdy, $urandom_range(0, 199) == 0);
      end
    end
    idle(3 * TO, 1);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
